// File: rtl/encoder4_2_seq_pkg.sv
// Shared types and constants for the 4-to-2 request encoder.
package enc4_pkg;

  localparam int NUM_LINES = 4;
  localparam int CODE_W    = 2;

  typedef logic [CODE_W-1:0]    code_t;
  typedef logic [NUM_LINES-1:0] mask_t;

  localparam code_t RST_CODE = 2'b00;

  function automatic mask_t onehot_of(input code_t code);
    mask_t m;
    m       = '0;
    m[code] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/encoder4_2_seq_if.sv
// Request/code bus of encoder4_2_seq; master is the encoder, slave the requester/consumer.
interface encoder4_2_seq_if;
  import enc4_pkg::*;

  mask_t In;
  code_t Out;
  logic  out_valid;
  logic  out_ready;
  mask_t pending;
  logic  overflow;

  modport master (
    input  In,
    input  out_ready,
    output Out,
    output out_valid,
    output pending,
    output overflow
  );

  modport slave (
    output In,
    output out_ready,
    input  Out,
    input  out_valid,
    input  pending,
    input  overflow
  );

endinterface

// File: rtl/encoder4_2_seq_prio_pick4.sv
// Combinational 4-way priority pick starting at a given index.
// ROUND_ROBIN_EN selects an upward search; otherwise the search runs downward.
module prio_pick4
  import enc4_pkg::*;
(
  input  mask_t mask,
  input  code_t start,
  output code_t idx,
  output logic  any
);

  code_t                cand [NUM_LINES];
  logic [NUM_LINES-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_cand
`ifdef ROUND_ROBIN_EN
      assign cand[gi] = start + code_t'(gi);
`else
      assign cand[gi] = start - code_t'(gi);
`endif
      assign hit[gi] = mask[cand[gi]];
    end
  endgenerate

  // Walk from the farthest candidate back so the nearest hit wins.
  always_comb begin
    idx = start;
    for (int k = NUM_LINES - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

  assign any = |mask;

endmodule

// File: rtl/encoder4_2_seq.sv
// Registered 4-to-2 request encoder with sticky pending requests and valid/ready output.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed priority, line 3 highest.
module encoder4_2_seq
  import enc4_pkg::*;
(
  input logic              clk,
  input logic              rst,
  encoder4_2_seq_if.master bus
);

  mask_t pending_reg;
  code_t out_reg;
  logic  out_valid_reg;
  logic  overflow_reg;

  mask_t merged;
  logic  load_en;
  code_t start;
  code_t pick_idx;
  logic  pick_any;

  assign merged  = pending_reg | bus.In;
  assign load_en = ~out_valid_reg | bus.out_ready;

`ifdef ROUND_ROBIN_EN
  code_t ptr_reg;
  assign start = ptr_reg + 2'd1;
`else
  assign start = code_t'(NUM_LINES - 1);
`endif

  prio_pick4 u_pick (
    .mask  (merged),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg   <= '0;
      out_reg       <= RST_CODE;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_reg       <= 2'd3;
`endif
    end else begin
      // A repeat on a still-pending line collapses into the existing request.
      overflow_reg <= |(bus.In & pending_reg);
      if (load_en) begin
        if (pick_any) begin
          out_reg       <= pick_idx;
          out_valid_reg <= 1'b1;
          pending_reg   <= merged & ~onehot_of(pick_idx);
`ifdef ROUND_ROBIN_EN
          ptr_reg       <= pick_idx;
`endif
        end else begin
          out_valid_reg <= 1'b0;
          pending_reg   <= '0;
        end
      end else begin
        pending_reg <= merged;
      end
    end
  end

  assign bus.Out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.pending   = pending_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_encoder4_2_seq.sv
// Randomized and directed bench for encoder4_2_seq against a set-based reference model.
module tb_encoder4_2_seq;
  import enc4_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  encoder4_2_seq_if bus ();

  encoder4_2_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending requests as a set of line flags.
  bit m_pend [4];
  bit m_valid;
  int m_out;
  bit m_ovf;
  int m_ptr;

  int obs_xfers;
  int dut_grants [4];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit m [4]);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      if (m[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic int pend_mask();
    int v;
    v = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_edge(input logic [3:0] in, input bit rdy, input bit r);
    bit merged [4];
    int s;
    if (r) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      m_valid = 0;
      m_out   = 0;
      m_ovf   = 0;
      m_ptr   = 3;
      return;
    end
    m_ovf = 0;
    for (int i = 0; i < 4; i++) begin
      if (in[i] && m_pend[i]) m_ovf = 1;
      merged[i] = m_pend[i] | in[i];
    end
    if (!m_valid || rdy) begin
      s = pick(merged);
      if (s >= 0) begin
        m_out     = s;
        m_valid   = 1;
        merged[s] = 0;
        m_ptr     = s;
        for (int i = 0; i < 4; i++) m_pend[i] = merged[i];
      end else begin
        m_valid = 0;
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) m_pend[i] = merged[i];
    end
  endtask

  task automatic step(input logic [3:0] in, input bit rdy, input bit r = 1'b0);
    bus.In        = in;
    bus.out_ready = rdy;
    rst           = r;
    if (!r && bus.out_valid && rdy) begin
      obs_xfers++;
      dut_grants[bus.Out]++;
      $display("xfer code=%0d", bus.Out);
    end
    @(posedge clk);
    model_edge(in, rdy, r);
    @(negedge clk);
    check_eq("out", bus.Out, m_out);
    check_eq("out_valid", bus.out_valid, m_valid);
    check_eq("pending", bus.pending, pend_mask());
    check_eq("overflow", bus.overflow, m_ovf);
  endtask

  int exp_burst [4];
  int exp_bp_out, exp_bp_pend, exp_rel_out;
  int exp_grants [4];

  initial begin
`ifdef ROUND_ROBIN_EN
    exp_burst  = '{3, 0, 1, 2};
    exp_bp_out = 0; exp_bp_pend = 2; exp_rel_out = 1;
    exp_grants = '{2, 2, 2, 2};
`else
    exp_burst  = '{3, 2, 1, 0};
    exp_bp_out = 1; exp_bp_pend = 1; exp_rel_out = 0;
    exp_grants = '{0, 0, 0, 8};
`endif
    bus.In = '0; bus.out_ready = 1'b0; rst = 1'b1;
    obs_xfers = 0;
    for (int i = 0; i < 4; i++) dut_grants[i] = 0;
    @(negedge clk);

    // Reset with all requests high, then release idle.
    step(4'hF, 1, 1);
    step(4'hF, 1, 1);
    step(4'h0, 1);
    check_eq("rst_out", bus.Out, 0);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_pending", bus.pending, 0);
    check_eq("rst_overflow", bus.overflow, 0);

    // Single request.
    step(4'b0100, 1);
    check_eq("single_out", bus.Out, 2);
    check_eq("single_valid", bus.out_valid, 1);
    step(4'h0, 1);
    check_eq("single_drain", bus.out_valid, 0);

    // Four simultaneous requests drain back to back.
    step(4'hF, 1);
    for (int k = 0; k < 4; k++) begin
      check_eq("burst_out", bus.Out, exp_burst[k]);
      check_eq("burst_valid", bus.out_valid, 1);
      step(4'h0, 1);
    end
    check_eq("burst_end", bus.out_valid, 0);

    // Backpressure holds the code and keeps the rest pending.
    step(4'b0011, 0);
    step(4'h0, 0);
    step(4'h0, 0);
    check_eq("bp_out", bus.Out, exp_bp_out);
    check_eq("bp_valid", bus.out_valid, 1);
    check_eq("bp_pending", bus.pending, exp_bp_pend);
    step(4'h0, 1);
    check_eq("bp_release", bus.Out, exp_rel_out);
    step(4'h0, 1);
    check_eq("bp_end", bus.out_valid, 0);

    // Duplicate request on a pending line pulses overflow once and merges.
    step(4'b0011, 0);
    step(4'(pend_mask()), 0);
    check_eq("ovf_pulse", bus.overflow, 1);
    step(4'h0, 0);
    check_eq("ovf_clear", bus.overflow, 0);
    obs_xfers = 0;
    step(4'h0, 1);
    step(4'h0, 1);
    step(4'h0, 1);
    check_eq("ovf_xfers", obs_xfers, 2);

    // All lines requesting continuously: grant distribution over 8 transfers.
    step(4'hF, 1);
    for (int i = 0; i < 4; i++) dut_grants[i] = 0;
    for (int k = 0; k < 8; k++) step(4'hF, 1);
    for (int i = 0; i < 4; i++) check_eq("grant_share", dut_grants[i], exp_grants[i]);
    step(4'h0, 1);
    step(4'h0, 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom & $urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
